// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared state encoding and byte width for the SPI transaction scheduler
package spi_sched_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after rr_ptr
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             valid
);

  logic [PTR_W:0]   idx_sum;
  logic [PTR_W-1:0] idx;

  // Walk the requesters starting at rr_ptr, wrapping past NREQ-1; the first set bit wins.
  always_comb begin
    gnt     = '0;
    valid   = 1'b0;
    idx_sum = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx_sum >= (PTR_W+1)'(NREQ)) begin
        idx_sum = idx_sum - (PTR_W+1)'(NREQ);
      end
      idx = idx_sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_sched.sv
// rtl/spi_txn_sched.sv - round-robin transaction scheduler framing multi-byte SPI transfers
module spi_txn_sched
  import spi_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic                       SPI_clk,
  input  logic                       Reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*LEN_W-1:0]      req_len,
  input  logic [NREQ*BYTE_BITS-1:0]  req_data,
  output logic [NREQ-1:0]            grant,
  output logic                       pop,
  output logic [NREQ-1:0]            done,
  output logic                       busy,
  output logic                       spi_cs_n,
  output logic [BYTE_BITS-1:0]       spi_tdata,
  output logic                       spi_tready
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  sched_state_t         state_q, state_d;
  logic [NREQ-1:0]      grant_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]     bytes_rem_q, bytes_rem_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 cs_n_d, tready_d, pop_d, busy_d;
  logic [BYTE_BITS-1:0] tdata_d;
  logic [NREQ-1:0]      done_d;

  logic [NREQ-1:0]      arb_gnt;
  logic                 arb_valid;
  logic [PTR_W-1:0]     arb_idx;
  logic [NREQ-1:0]      sel;
  logic [BYTE_BITS-1:0] sel_data;
  logic [LEN_W-1:0]     sel_len;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .valid  (arb_valid)
  );

  // Index of the arbiter winner, kept so the pointer can advance past the owner later.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  // Byte/length muxes: the arbiter winner while choosing, the registered owner afterwards.
  always_comb begin
    sel      = (state_q == ST_IDLE) ? arb_gnt : grant;
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        sel_data = req_data[i*BYTE_BITS +: BYTE_BITS];
        sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    bit_cnt_d   = bit_cnt_q;
    bytes_rem_d = bytes_rem_q;
    gap_cnt_d   = gap_cnt_q;
    tdata_d     = spi_tdata;
    cs_n_d      = 1'b1;
    tready_d    = 1'b0;
    pop_d       = 1'b0;
    done_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d     = ST_SETUP;
          grant_d     = arb_gnt;
          owner_d     = arb_idx;
          bytes_rem_d = sel_len;
          tdata_d     = sel_data;
          tready_d    = 1'b1;
          pop_d       = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_XFER;
        bit_cnt_d = 3'd0;
        cs_n_d    = 1'b0;
      end
      ST_XFER: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        cs_n_d    = 1'b0;
        if (bit_cnt_q == 3'd7) begin
          if (bytes_rem_q == '0) begin
            state_d   = ST_GAP;
            cs_n_d    = 1'b1;
            done_d    = grant;
            gap_cnt_d = '0;
          end else begin
            bytes_rem_d = bytes_rem_q - LEN_W'(1);
          end
        end else if (bit_cnt_q == 3'd6 && bytes_rem_q != '0) begin
          // Load the next byte so it is on T_Data during the last bit of the current one.
          tdata_d  = sel_data;
          tready_d = 1'b1;
          pop_d    = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          gap_cnt_d = '0;
          rr_ptr_d  = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and outputs; reset drops chip-select at once without a done pulse.
  always_ff @(posedge SPI_clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      grant       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      bit_cnt_q   <= '0;
      bytes_rem_q <= '0;
      gap_cnt_q   <= '0;
      spi_cs_n    <= 1'b1;
      spi_tdata   <= '0;
      spi_tready  <= 1'b0;
      pop         <= 1'b0;
      done        <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      bit_cnt_q   <= bit_cnt_d;
      bytes_rem_q <= bytes_rem_d;
      gap_cnt_q   <= gap_cnt_d;
      spi_cs_n    <= cs_n_d;
      spi_tdata   <= tdata_d;
      spi_tready  <= tready_d;
      pop         <= pop_d;
      done        <= done_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_txn_sched.sv
// tb/tb_spi_txn_sched.sv - scoreboard bench for the SPI transaction scheduler
module tb_spi_txn_sched;
  import spi_sched_pkg::*;

  localparam int NREQ    = 4;
  localparam int LEN_W   = 4;
  localparam int GAP_CYC = 2;

  typedef struct { int owner; int len; } txn_t;
  typedef struct { int owner; logic [7:0] data; } byte_t;

  logic                  SPI_clk = 1'b0;
  logic                  Reset = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [NREQ*8-1:0]     req_data;
  logic [NREQ-1:0]       grant, done;
  logic                  pop, busy, spi_cs_n, spi_tready;
  logic [7:0]            spi_tdata;

  logic [7:0] bytes_of [NREQ][16];
  int         ptr [NREQ];
  int         remaining [NREQ];
  txn_t       exp_txns [$];
  byte_t      exp_bytes [$];
  txn_t       mon_t;
  byte_t      mon_b;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int cs_low = 0;
  int pops = 0;
  int first_pop_cyc = 0;
  int done_cyc = 0;
  bit cs_prev_low = 1'b0;
  bit chk_gap = 1'b0;

  spi_txn_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC)) dut (
    .SPI_clk    (SPI_clk),
    .Reset      (Reset),
    .req        (req),
    .req_len    (req_len),
    .req_data   (req_data),
    .grant      (grant),
    .pop        (pop),
    .done       (done),
    .busy       (busy),
    .spi_cs_n   (spi_cs_n),
    .spi_tdata  (spi_tdata),
    .spi_tready (spi_tready)
  );

  always #5 SPI_clk = ~SPI_clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = bytes_of[i][ptr[i][3:0]];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_len(input int owner, input int len);
    req_len[owner*LEN_W +: LEN_W] = len[LEN_W-1:0];
  endtask

  task automatic push_txn(input int owner, input int len);
    txn_t t;
    byte_t b;
    t.owner = owner;
    t.len = len;
    exp_txns.push_back(t);
    for (int k = 0; k <= len; k++) begin
      b.owner = owner;
      b.data = bytes_of[owner][k];
      exp_bytes.push_back(b);
    end
  endtask

  task automatic run_txns(input int max_cyc, input bit gap_chk);
    int n;
    int rem_total;
    n = 0;
    forever begin
      @(negedge SPI_clk);
      #1;
      n++;
      rem_total = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] && remaining[i] > 0) begin
          remaining[i]--;
          if (remaining[i] == 0) req[i] = 1'b0;
        end
        rem_total += remaining[i];
      end
      if (done != '0 && gap_chk) chk_gap = 1'b1;
      if (rem_total == 0 && !busy) break;
      if (n >= max_cyc) begin
        check("txn_timeout", rem_total + int'(busy), 0);
        break;
      end
    end
    chk_gap = 1'b0;
  endtask

  task automatic wait_xfer(input int owner, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge SPI_clk);
      n++;
    end while (!(grant[owner] && !spi_cs_n) && n < max_cyc);
    check("wait_xfer_bound", grant[owner] && !spi_cs_n, 1);
  endtask

  always @(negedge SPI_clk) begin
    cyc++;
    if (!Reset) begin
      for (int i = 0; i < NREQ; i++) ptr[i] = 0;
    end else begin
      if (!spi_cs_n) begin
        if (!cs_prev_low) check("cs_fall_latency", cyc - first_pop_cyc, 1);
        cs_low++;
      end
      cs_prev_low = !spi_cs_n;
      if (pop || spi_tready) check("pop_with_tready", pop, spi_tready);
      if (spi_tready) begin
        if (pops == 0) begin
          first_pop_cyc = cyc;
          if (chk_gap) check("done_to_grant", cyc - done_cyc, GAP_CYC + 1);
        end
        check("pop_spacing", cyc - first_pop_cyc, 8 * pops);
        pops++;
        if (exp_bytes.size() == 0) begin
          check("unexpected_byte", exp_bytes.size(), 1);
        end else begin
          mon_b = exp_bytes.pop_front();
          check("tdata", spi_tdata, mon_b.data);
          check("byte_owner", grant, 1 << mon_b.owner);
        end
        for (int i = 0; i < NREQ; i++) if (grant[i] && ptr[i] < 15) ptr[i]++;
      end
      if (done != '0) begin
        if (exp_txns.size() == 0) begin
          check("unexpected_done", exp_txns.size(), 1);
        end else begin
          mon_t = exp_txns.pop_front();
          check("done_owner", done, 1 << mon_t.owner);
          check("cs_low_cycles", cs_low, 8 * (mon_t.len + 1));
          check("pop_count", pops, mon_t.len + 1);
        end
        check("cs_high_at_done", spi_cs_n, 1);
        for (int i = 0; i < NREQ; i++) if (done[i]) ptr[i] = 0;
        cs_low = 0;
        pops = 0;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ptr[i] = 0;
      remaining[i] = 0;
      for (int k = 0; k < 16; k++) bytes_of[i][k] = 8'(8'h40 + 16 * i + k);
    end

    repeat (3) @(negedge SPI_clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_tdata", spi_tdata, 0);
    check("rst_tready", spi_tready, 0);
    check("rst_grant", grant, 0);
    check("rst_pop", pop, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    #1 Reset = 1'b1;
    @(negedge SPI_clk);
    check("idle_busy", busy, 0);
    #1;

    // Fairness: every requester held high, grants 0,1,2,3,0.
    set_len(0, 1); set_len(1, 0); set_len(2, 1); set_len(3, 0);
    push_txn(0, 1); push_txn(1, 0); push_txn(2, 1); push_txn(3, 0); push_txn(0, 1);
    remaining[0] = 2; remaining[1] = 1; remaining[2] = 1; remaining[3] = 1;
    req = '1;
    run_txns(400, 1'b1);

    // Single one-byte transaction with explicit latency checks.
    bytes_of[0][0] = 8'hA5;
    set_len(0, 0);
    push_txn(0, 0);
    remaining[0] = 1;
    req[0] = 1'b1;
    @(negedge SPI_clk);
    check("t1_grant", grant, 4'b0001);
    check("t1_pop", pop, 1);
    check("t1_tready", spi_tready, 1);
    check("t1_tdata", spi_tdata, 8'hA5);
    check("t1_cs_n_setup", spi_cs_n, 1);
    check("t1_busy", busy, 1);
    @(negedge SPI_clk);
    check("t1_cs_n_xfer", spi_cs_n, 0);
    #1;
    run_txns(100, 1'b0);

    // Multi-byte transaction from requester 2.
    bytes_of[2][0] = 8'h11; bytes_of[2][1] = 8'h22; bytes_of[2][2] = 8'h33;
    set_len(2, 2);
    push_txn(2, 2);
    remaining[2] = 1;
    req[2] = 1'b1;
    run_txns(100, 1'b0);

    // Pointer wrap: rr_ptr is 3, requesters 3 and 0; length change in XFER ignored.
    bytes_of[3][0] = 8'hC1; bytes_of[3][1] = 8'hC2;
    bytes_of[0][0] = 8'hD1; bytes_of[0][1] = 8'hD2; bytes_of[0][2] = 8'hD3;
    set_len(3, 1); set_len(0, 2);
    push_txn(3, 1); push_txn(0, 2);
    remaining[3] = 1; remaining[0] = 1;
    req = 4'b1001;
    wait_xfer(3, 10);
    #1 set_len(3, 7);
    run_txns(200, 1'b0);

    // Reset mid-transaction at bit_cnt 3.
    bytes_of[1][0] = 8'h51; bytes_of[1][1] = 8'h52; bytes_of[0][0] = 8'h61;
    set_len(1, 1); set_len(0, 0);
    push_txn(1, 1);
    remaining[0] = 1; remaining[1] = 1;
    req = 4'b0011;
    wait_xfer(1, 10);
    repeat (3) @(negedge SPI_clk);
    #1 Reset = 1'b0;
    #1;
    check("mid_rst_cs_n", spi_cs_n, 1);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tready", spi_tready, 0);
    check("mid_rst_done", done, 0);
    exp_txns.delete();
    exp_bytes.delete();
    cs_low = 0;
    pops = 0;
    cs_prev_low = 1'b0;
    push_txn(0, 0); push_txn(1, 1);
    @(negedge SPI_clk);
    #1 Reset = 1'b1;
    run_txns(200, 1'b0);

    // Request dropped early in a 16-byte transfer.
    set_len(3, 15);
    for (int k = 0; k < 16; k++) bytes_of[3][k] = 8'(8'h80 + k);
    push_txn(3, 15);
    remaining[3] = 1;
    req[3] = 1'b1;
    wait_xfer(3, 10);
    repeat (5) @(negedge SPI_clk);
    #1 req[3] = 1'b0;
    run_txns(300, 1'b0);

    check("exp_txns_left", exp_txns.size(), 0);
    check("exp_bytes_left", exp_bytes.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
